// File: rtl/rs_flipflop_bank_if.sv
// Request/status bundle for rs_flipflop_bank: per-channel set/reset requests and clear in,
// latch state, complement, sticky conflict flags and change pulse out.
interface rs_flipflop_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] conflict;
    logic             chg;

    modport master (output s, r, clr, input q, n, conflict, chg);
    modport slave  (input s, r, clr, output q, n, conflict, chg);
endinterface

// File: rtl/rs_flipflop_bank.sv
// Bank of WIDTH independent RS latches with selectable s&r priority, sticky conflict flags and a change pulse.
// Define RSBANK_FILTER_EN to qualify every s and r input over FILT consecutive edges before it reaches the latch.
module rs_flipflop_bank #(
    parameter int               WIDTH = 4,
    parameter int               PRIO  = 0,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               FILT  = 3
) (
    input logic               clk,
    input logic               rst_n,
    rs_flipflop_bank_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("rs_flipflop_bank: WIDTH must be within 1..32");
    end
    if (PRIO < 0 || PRIO > 3) begin : g_bad_prio
        $error("rs_flipflop_bank: PRIO must be within 0..3");
    end
    if (FILT < 1 || FILT > 15) begin : g_bad_filt
        $error("rs_flipflop_bank: FILT must be within 1..15");
    end

    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] r_eff;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] conflict_reg;
    logic             chg_reg;

    function automatic logic [WIDTH-1:0] resolve(
        input logic [WIDTH-1:0] q_cur,
        input logic [WIDTH-1:0] set_req,
        input logic [WIDTH-1:0] rst_req
    );
        logic [WIDTH-1:0] q_new;
        q_new = q_cur;
        for (int i = 0; i < WIDTH; i++) begin
            case ({set_req[i], rst_req[i]})
                2'b10:   q_new[i] = 1'b1;
                2'b01:   q_new[i] = 1'b0;
                2'b11: begin
                    case (PRIO)
                        1:       q_new[i] = 1'b1;
                        2:       q_new[i] = 1'b0;
                        3:       q_new[i] = ~q_cur[i];
                        default: q_new[i] = q_cur[i];
                    endcase
                end
                default: q_new[i] = q_cur[i];
            endcase
        end
        return q_new;
    endfunction

`ifdef RSBANK_FILTER_EN
    localparam logic [3:0] FILT_LEN = 4'(FILT);

    logic [WIDTH-1:0]      s_filt;
    logic [WIDTH-1:0]      r_filt;
    logic [WIDTH-1:0]      s_filt_nxt;
    logic [WIDTH-1:0]      r_filt_nxt;
    logic [WIDTH-1:0][3:0] s_cnt;
    logic [WIDTH-1:0][3:0] r_cnt;
    logic [WIDTH-1:0][3:0] s_cnt_nxt;
    logic [WIDTH-1:0][3:0] r_cnt_nxt;

    // Returns {filtered, count}; the count tracks consecutive edges where raw disagrees.
    function automatic logic [4:0] qualify(
        input logic       raw,
        input logic       filt,
        input logic [3:0] cnt
    );
        if (raw == filt)
            return {filt, 4'd0};
        else if (cnt + 4'd1 >= FILT_LEN)
            return {raw, 4'd0};
        else
            return {filt, cnt + 4'd1};
    endfunction

    always_comb begin
        s_filt_nxt = s_filt;
        r_filt_nxt = r_filt;
        s_cnt_nxt  = s_cnt;
        r_cnt_nxt  = r_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            {s_filt_nxt[i], s_cnt_nxt[i]} = qualify(bus.s[i], s_filt[i], s_cnt[i]);
            {r_filt_nxt[i], r_cnt_nxt[i]} = qualify(bus.r[i], r_filt[i], r_cnt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_filt <= '0;
            r_filt <= '0;
            s_cnt  <= '0;
            r_cnt  <= '0;
        end else if (bus.clr) begin
            s_filt <= '0;
            r_filt <= '0;
            s_cnt  <= '0;
            r_cnt  <= '0;
        end else begin
            s_filt <= s_filt_nxt;
            r_filt <= r_filt_nxt;
            s_cnt  <= s_cnt_nxt;
            r_cnt  <= r_cnt_nxt;
        end
    end

    // The latch sees the value qualified on this very edge, so latency is exactly FILT edges.
    assign s_eff = s_filt_nxt;
    assign r_eff = r_filt_nxt;
`else
    assign s_eff = bus.s;
    assign r_eff = bus.r;
`endif

    assign q_nxt = resolve(q_reg, s_eff, r_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg        <= INIT;
            conflict_reg <= '0;
            chg_reg      <= 1'b0;
        end else if (bus.clr) begin
            q_reg        <= INIT;
            conflict_reg <= '0;
            chg_reg      <= (q_reg != INIT);
        end else begin
            q_reg        <= q_nxt;
            conflict_reg <= conflict_reg | (s_eff & r_eff);
            chg_reg      <= (q_nxt != q_reg);
        end
    end

    assign bus.q        = q_reg;
    assign bus.n        = ~q_reg;
    assign bus.conflict = conflict_reg;
    assign bus.chg      = chg_reg;

endmodule

// File: doc/rs_flipflop_bank.md
RS_FLIPFLOP_BANK -- requirements
Module: rs_flipflop_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent RS channels, 1..32.
REQ-002 Parameter PRIO, default 0: simultaneous s&r resolution; 0=hold, 1=set wins, 2=reset wins, 3=toggle.
REQ-003 Parameter INIT, default all-zero, WIDTH bits: per-channel q value at reset and on clr.
REQ-004 Parameter FILT, default 3: input qualification length in cycles, 1..15; used only with RSBANK_FILTER_EN.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 s  input  WIDTH  per-channel set request, level-sensitive, sampled on clk.
REQ-008 r  input  WIDTH  per-channel reset request, level-sensitive, sampled on clk.
REQ-009 clr  input  1  synchronous clear: q to INIT, conflict to 0, filters to idle.
REQ-010 q  output  WIDTH  registered latch state.
REQ-011 n  output  WIDTH  always the bitwise complement of q, including during reset.
REQ-012 conflict  output  WIDTH  sticky per-channel flag: s and r both effective on the same edge.
REQ-013 chg  output  1  one-cycle pulse: at least one q bit changed on the previous edge.

Function
REQ-014 Per channel, the next q is: s only -> 1; r only -> 0; neither -> hold; both -> per PRIO (hold / 1 / 0 / ~q).
REQ-015 Without the filter, s/r present at edge k take effect in q at edge k (one-edge latency).
REQ-016 The conflict bit sets at the edge where both effective s and r are 1; it stays set, regardless of PRIO, until clr or reset.
REQ-017 chg is 1 for exactly the cycle following an edge that changed any q bit, and 0 otherwise.
REQ-018 clr has priority over s/r on the same edge: q=INIT, conflict=0, chg=1 only if q actually changed.
REQ-019 Channels are fully independent; activity on one channel never alters another channel's q or conflict.
REQ-020 With PRIO=3 and s=r=1 held, q toggles every edge and chg stays high.

Reset
REQ-021 While rst_n=0, immediately (no clock needed): q=INIT, n=~INIT, conflict=0, chg=0, all filter counters and filtered values 0.
REQ-022 Deassertion of rst_n takes effect at the next rising edge; the first edge with rst_n=1 samples s/r normally.
REQ-023 Reset asserted mid-filter-count discards the partial count; no q change results.

Configuration
REQ-024 Macro RSBANK_FILTER_EN, when defined, compiles in per-channel, per-input qualification.
- A filtered value changes only after the raw input differs from it at FILT consecutive edges.
- Any edge with raw equal to filtered clears the count.
- q uses the newly qualified value on the FILT-th edge; latency is FILT edges; FILT=1 behaves identically to no filter.
REQ-025 Without RSBANK_FILTER_EN, s/r feed REQ-014 directly, FILT is ignored, and no filter state exists.
REQ-026 Filters apply to both assertion and deassertion of s and r; conflict and chg evaluate qualified values.

Verification
REQ-027 WIDTH=4, INIT=0, no filter: rst_n=0 -> q=0000, n=1111, chg=0. Then s=0001 for one edge -> q=0001, chg=1 for one cycle. Then s=0, r=0001 -> q=0000.
REQ-028 PRIO=1/2/0/3, q=0, s=r=0001 for one edge -> q[0]=1/0/0/1 respectively; conflict[0]=1 in all cases and persists until a clr pulse, then 0.
REQ-029 Filter build, FILT=3: s[2] high for 2 edges then low -> q unchanged. s[2] high for 3 edges -> q[2]=1 on the third edge, chg=1 in the next cycle.
REQ-030 INIT=1010: q=0101 set, then clr with s=1111 on the same edge -> q=1010, conflict=0000.
REQ-031 Filter build: rst_n pulsed low between the 2nd and 3rd qualifying edges -> q=INIT immediately, and a further 3 edges are required before q changes.
